// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    // Sequential successor; the 32-bit add wraps naturally at the top of memory.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/fetch_seq_ctrl_redirect_sel.sv
// Picks the winning redirect among the four sources (ex > jr > j > br).
module redirect_sel
    import fetch_seq_ctrl_pkg::*;
(
    input  logic        ex_taken,
    input  logic        jr_taken,
    input  logic        j_taken,
    input  logic        br_taken,
    input  logic [31:0] ex_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] j_target,
    input  logic [31:0] br_target,
    output logic        taken,
    output logic [31:0] target
);

    always_comb begin
        taken  = ex_taken | jr_taken | j_taken | br_taken;
        target = br_target;
        if (ex_taken) begin
            target = ex_target;
        end else if (jr_taken) begin
            target = jr_target;
        end else if (j_taken) begin
            target = j_target;
        end
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Instruction fetch sequencer: one outstanding memory request, redirect and
// cancel handling, and a single held entry presented to decode.
module fetch_seq_ctrl
    import fetch_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_taken,
    input  logic        jr_taken,
    input  logic        j_taken,
    input  logic        br_taken,
    input  logic [31:0] ex_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] j_target,
    input  logic [31:0] br_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        if_valid_out,
    output logic [31:0] if_pc_out,
    output logic [31:0] if_inst_out,
    output logic        if_adel_out,
    input  logic        if_allow_out
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         cancel_q, cancel_d;
    logic [31:0]  inst_q, inst_d;
    logic         adel_q, adel_d;

    logic         redir_taken;
    logic [31:0]  redir_target;
    logic         pc_aligned;
    logic         issue;

    redirect_sel u_redirect_sel (
        .ex_taken  (ex_taken),
        .jr_taken  (jr_taken),
        .j_taken   (j_taken),
        .br_taken  (br_taken),
        .ex_target (ex_target),
        .jr_target (jr_target),
        .j_target  (j_target),
        .br_target (br_target),
        .taken     (redir_taken),
        .target    (redir_target)
    );

    assign pc_aligned = (fetch_pc_q[1:0] == 2'b00);

    // No new request while a response abandoned by reset is still due back.
    assign issue = (state_q == ST_REQ) && pc_aligned && !cancel_q && !reset;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        cancel_d   = cancel_q;
        inst_d     = inst_q;
        adel_d     = adel_q;

        unique case (state_q)
            ST_REQ: begin
                if (cancel_q && inst_data_ok) begin
                    cancel_d = 1'b0;
                end
                if (redir_taken) begin
                    fetch_pc_d = redir_target;
                    if (issue && inst_addr_ok) begin
                        state_d  = ST_WAIT;
                        cancel_d = 1'b1;
                    end
                end else if (!pc_aligned) begin
                    state_d = ST_HOLD;
                    inst_d  = '0;
                    adel_d  = 1'b1;
                end else if (issue && inst_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (redir_taken) begin
                    fetch_pc_d = redir_target;
                end
                // A response coinciding with a redirect is already stale.
                if (inst_data_ok) begin
                    if (cancel_q || redir_taken) begin
                        state_d  = ST_REQ;
                        cancel_d = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                        inst_d  = inst_rdata;
                        adel_d  = 1'b0;
                    end
                end else if (redir_taken) begin
                    cancel_d = 1'b1;
                end
            end

            ST_HOLD: begin
                if (cancel_q && inst_data_ok) begin
                    cancel_d = 1'b0;
                end
                if (redir_taken) begin
                    fetch_pc_d = redir_target;
                    state_d    = ST_REQ;
                end else if (if_allow_out) begin
                    fetch_pc_d = next_seq_pc(fetch_pc_q);
                    state_d    = ST_REQ;
                end
            end

            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Reset out of WAIT leaves a response in flight, so cancel is armed to eat it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            cancel_q   <= (state_q == ST_WAIT);
            inst_q     <= '0;
            adel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            cancel_q   <= cancel_d;
            inst_q     <= inst_d;
            adel_q     <= adel_d;
        end
    end

    assign inst_req     = issue;
    assign inst_addr    = fetch_pc_q;
    assign if_valid_out = (state_q == ST_HOLD) && !reset;
    assign if_pc_out    = reset ? RESET_PC : fetch_pc_q;
    assign if_inst_out  = if_valid_out ? inst_q : 32'h0000_0000;
    assign if_adel_out  = if_valid_out && adel_q;

endmodule
